// File: rtl/apb_multi_arbiter.sv
// Shares one APB slave among NUM_MASTERS requesters using round-robin or
// fixed-priority arbitration, with an optional ACCESS-phase timeout.
module apb_multi_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_MASTERS    = 4,
   parameter int PRIORITY_MODE  = 0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_MASTERS-1:0]                 m_psel,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_paddr,
   input  logic [NUM_MASTERS*3-1:0]               m_pprot,
   input  logic [NUM_MASTERS-1:0]                 m_pwrite,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_pwdata,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_pstrb,
   output logic [NUM_MASTERS-1:0]                 m_pready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_prdata,
   output logic [NUM_MASTERS-1:0]                 m_pslverr,
   output logic                                   s_psel,
   output logic                                   s_penable,
   output logic [ADDR_WIDTH-1:0]                  s_paddr,
   output logic [2:0]                             s_pprot,
   output logic                                   s_pwrite,
   output logic [DATA_WIDTH-1:0]                  s_pwdata,
   output logic [DATA_WIDTH/8-1:0]                s_pstrb,
   input  logic                                   s_pready,
   input  logic [DATA_WIDTH-1:0]                  s_prdata,
   input  logic                                   s_pslverr,
   output logic [NUM_MASTERS-1:0]                 grant,
   output logic                                   busy,
   output logic                                   timeout_pulse
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      SETUP  = 3'b010,
      ACCESS = 3'b100
   } state_t;

   state_t                 state, state_n;
   logic [NUM_MASTERS-1:0] grant_n;
   logic [LW-1:0]          last, last_n;
   logic [CW-1:0]          cnt, cnt_n;

   logic [NUM_MASTERS-1:0] win_oh;
   logic [LW-1:0]          win_idx;
   logic [LW-1:0]          cidx;
   logic                   found;
   logic                   in_access;
   logic                   tmo_hit;
   logic                   done;

   // Winner search: fixed mode scans from 0, round-robin scans from last+1.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      cidx    = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (PRIORITY_MODE == 1)
            cidx = LW'(k);
         else
            cidx = LW'((int'(last) + 1 + k) % NUM_MASTERS);
         if (!found && m_psel[cidx]) begin
            found         = 1'b1;
            win_idx       = cidx;
            win_oh[cidx]  = 1'b1;
         end
      end
   end

   assign in_access     = (state == ACCESS);
   assign busy          = (state == SETUP) || in_access;
   assign s_psel        = busy;
   assign s_penable     = in_access;
   assign tmo_hit       = TO_EN && in_access && !s_pready && (cnt == CNT_LAST);
   assign done          = in_access && (s_pready || tmo_hit);
   assign timeout_pulse = tmo_hit;

   always_comb begin
      s_paddr  = '0;
      s_pprot  = '0;
      s_pwrite = 1'b0;
      s_pwdata = '0;
      s_pstrb  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) begin
            s_paddr  |= m_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            s_pprot  |= m_pprot[i*3 +: 3];
            s_pwrite |= m_pwrite[i];
            s_pwdata |= m_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_pstrb  |= m_pstrb[i*SW +: SW];
         end
      end
   end

   // A master that dropped psel mid-transfer gets no completion.
   always_comb begin
      m_pready  = '0;
      m_pslverr = '0;
      m_prdata  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (done && grant[i] && m_psel[i]) begin
            m_pready[i]                          = 1'b1;
            m_pslverr[i]                         = tmo_hit | s_pslverr;
            m_prdata[i*DATA_WIDTH +: DATA_WIDTH] = tmo_hit ? '0 : s_prdata;
         end
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      last_n  = last;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = SETUP;
               grant_n = win_oh;
               last_n  = win_idx;
               cnt_n   = '0;
            end
         end
         SETUP: begin
            state_n = ACCESS;
            cnt_n   = '0;
         end
         ACCESS: begin
            if (done) begin
               state_n = IDLE;
               grant_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         last  <= LW'(NUM_MASTERS - 1);
         cnt   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         last  <= last_n;
         cnt   <= cnt_n;
      end
   end

endmodule

// File: tb/tb_apb_multi_arbiter.sv
// Bench for apb_multi_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are compared every cycle against a transfer-level model.
module tb_apb_multi_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]    m_psel;
   logic [N*AW-1:0] m_paddr;
   logic [N*3-1:0]  m_pprot;
   logic [N-1:0]    m_pwrite;
   logic [N*DW-1:0] m_pwdata;
   logic [N*SW-1:0] m_pstrb;
   logic            s_pready;
   logic [DW-1:0]   s_prdata;
   logic            s_pslverr;

   // index 0: round-robin instance, index 1: fixed-priority instance
   logic [N-1:0]    d_pready  [2];
   logic [N*DW-1:0] d_prdata  [2];
   logic [N-1:0]    d_pslverr [2];
   logic            d_psel    [2];
   logic            d_penable [2];
   logic [AW-1:0]   d_paddr   [2];
   logic [2:0]      d_pprot   [2];
   logic            d_pwrite  [2];
   logic [DW-1:0]   d_pwdata  [2];
   logic [SW-1:0]   d_pstrb   [2];
   logic [N-1:0]    d_grant   [2];
   logic            d_busy    [2];
   logic            d_tpulse  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      apb_multi_arbiter #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N),
         .PRIORITY_MODE(g), .TIMEOUT_CYCLES(TO)
      ) dut (
         .clk(clk), .rst(rst),
         .m_psel(m_psel), .m_paddr(m_paddr), .m_pprot(m_pprot),
         .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
         .m_pready(d_pready[g]), .m_prdata(d_prdata[g]), .m_pslverr(d_pslverr[g]),
         .s_psel(d_psel[g]), .s_penable(d_penable[g]), .s_paddr(d_paddr[g]),
         .s_pprot(d_pprot[g]), .s_pwrite(d_pwrite[g]), .s_pwdata(d_pwdata[g]),
         .s_pstrb(d_pstrb[g]),
         .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
         .grant(d_grant[g]), .busy(d_busy[g]), .timeout_pulse(d_tpulse[g])
      );
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Transfer-level model: owner of the bus (-1 = none), cycles since grant,
   // and the most recently granted master.
   int own [2] = '{-1, -1};
   int age [2] = '{0, 0};
   int ptr [2] = '{N-1, N-1};

   function automatic bit to_hit(int k);
      return (own[k] >= 0) && (age[k] == TO) && !s_pready;
   endfunction

   function automatic bit fin(int k);
      return (own[k] >= 0) && (age[k] >= 1) && (s_pready || to_hit(k));
   endfunction

   function automatic int pick(int k);
      int c;
      for (int j = 0; j < N; j++) begin
         c = (k == 1) ? j : (ptr[k] + 1 + j) % N;
         if (m_psel[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            own[k] = -1;
            age[k] = 0;
            ptr[k] = N - 1;
         end else if (own[k] < 0) begin
            if (m_psel != '0) begin
               own[k] = pick(k);
               ptr[k] = own[k];
               age[k] = 0;
            end
         end else if (fin(k)) begin
            own[k] = -1;
         end else begin
            age[k]++;
         end
      end
   end

   bit              chk_on = 1'b0;
   logic [N-1:0]    e_grant, e_pready, e_pslverr;
   logic [N*DW-1:0] e_prdata;
   logic [71:0]     e_sreq;
   logic            e_to, e_fin, e_act;
   int              o;

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            e_grant   = '0;
            e_pready  = '0;
            e_pslverr = '0;
            e_prdata  = '0;
            e_sreq    = '0;
            e_act     = (own[k] >= 0);
            e_to      = to_hit(k);
            e_fin     = fin(k);
            if (e_act) begin
               o       = own[k];
               e_grant = N'(1) << o;
               e_sreq  = {m_paddr[o*AW +: AW], m_pprot[o*3 +: 3], m_pwrite[o],
                          m_pwdata[o*DW +: DW], m_pstrb[o*SW +: SW]};
               if (e_fin && m_psel[o]) begin
                  e_pready[o]          = 1'b1;
                  e_pslverr[o]         = e_to ? 1'b1 : s_pslverr;
                  e_prdata[o*DW +: DW] = e_to ? '0 : s_prdata;
               end
            end
            check($sformatf("grant%0d", k), d_grant[k], e_grant);
            check($sformatf("ctrl%0d", k),
                  {d_busy[k], d_psel[k], d_penable[k], d_tpulse[k]},
                  {e_act, e_act, e_act && (age[k] >= 1), e_to});
            check($sformatf("sreq%0d", k),
                  {d_paddr[k], d_pprot[k], d_pwrite[k], d_pwdata[k], d_pstrb[k]}, e_sreq);
            check($sformatf("cpl%0d", k),
                  {d_pready[k], d_pslverr[k], d_prdata[k]}, {e_pready, e_pslverr, e_prdata});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         m_paddr[i*AW +: AW]  = $urandom;
         m_pprot[i*3 +: 3]    = 3'($urandom);
         m_pwrite[i]          = 1'($urandom);
         m_pwdata[i*DW +: DW] = $urandom;
         m_pstrb[i*SW +: SW]  = SW'($urandom);
      end
   endtask

   int rr_seq [5] = '{0, 1, 2, 3, 0};
   int rr_alt [4] = '{1, 3, 1, 3};
   int n;

   initial begin
      rst = 1'b1;
      m_psel = '0; m_paddr = '0; m_pprot = '0; m_pwrite = '0;
      m_pwdata = '0; m_pstrb = '0;
      s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
      repeat (3) tick();
      chk_on = 1'b1;
      check("rst_grant", {d_grant[1], d_grant[0]}, 8'h00);
      check("rst_busy", {d_busy[1], d_busy[0], d_psel[1], d_psel[0]}, 4'h0);

      // single master 2 write
      rst = 1'b0;
      m_psel = 4'b0100;
      m_paddr[2*AW +: AW]  = 32'h1000_0040;
      m_pwrite[2]          = 1'b1;
      m_pwdata[2*DW +: DW] = 32'hDEAD_BEEF;
      s_pready = 1'b1;
      s_prdata = 32'hCAFE_0001;
      tick();
      check("c1_setup", {d_psel[0], d_penable[0], d_grant[0]}, {1'b1, 1'b0, 4'b0100});
      tick();
      check("c2_access", {d_psel[0], d_penable[0], d_pwdata[0], d_paddr[0]},
            {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1000_0040});
      check("c2_pready", {d_pready[1], d_pready[0]}, 8'b0100_0100);
      check("c2_prdata", d_prdata[0][2*DW +: DW], 32'hCAFE_0001);
      m_psel = '0;
      tick();

      // all four requesting: round-robin from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_psel = 4'b1111;
      s_pready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         check($sformatf("rr_seq%0d", j), d_grant[0], N'(1) << rr_seq[j]);
         check($sformatf("fp_seq%0d", j), d_grant[1], 4'b0001);
         tick();
         tick();
      end
      m_psel = '0;
      repeat (3) tick();

      // masters 1 and 3 continuously
      m_psel = 4'b1010;
      for (int j = 0; j < 4; j++) begin
         tick();
         check($sformatf("fp13_%0d", j), d_grant[1], 4'b0010);
         check($sformatf("rr13_%0d", j), d_grant[0], N'(1) << rr_alt[j]);
         tick();
         tick();
      end
      m_psel = '0;
      repeat (3) tick();

      // slave never ready: timeout on the 8th ACCESS cycle
      m_psel = 4'b0001;
      s_pready = 1'b0;
      s_prdata = 32'hA5A5_5A5A;
      s_pslverr = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!d_tpulse[0] && n < 40);
      check("to_cycle", n, 9);
      check("to_pulse", {d_tpulse[1], d_tpulse[0]}, 2'b11);
      check("to_cpl", {d_pready[0], d_pslverr[0], d_prdata[0]}, {4'b0001, 4'b0001, 128'h0});
      tick();
      s_pready = 1'b1;
      s_prdata = 32'h1234_5678;
      tick();
      tick();
      check("after_to", {d_pready[0], d_pslverr[0], d_prdata[0][DW-1:0], d_tpulse[0]},
            {4'b0001, 4'b0000, 32'h1234_5678, 1'b0});
      tick();
      s_pready = 1'b0;
      tick();
      repeat (8) tick();
      s_pready = 1'b1;
      s_prdata = 32'h0BAD_F00D;
      #1;
      check("ready_wins", {d_pready[0], d_pslverr[0], d_prdata[0][DW-1:0], d_tpulse[0]},
            {4'b0001, 4'b0000, 32'h0BAD_F00D, 1'b0});
      m_psel = '0;
      tick();
      s_pready = 1'b0;
      tick();

      // reset in the middle of ACCESS
      m_psel = 4'b0001;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid", {d_psel[0], d_penable[0], d_grant[0], d_grant[1], d_pready[0]},
            {1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000});
      m_psel = 4'b0101;
      rst = 1'b0;
      tick();
      check("rst_then", {d_grant[0], d_grant[1]}, 8'b0001_0001);

      // granted master drops its request: slave still finishes, no completion
      m_psel = 4'b0100;
      s_pready = 1'b1;
      tick();
      check("drop", {d_psel[0], d_penable[0], d_pready[0], d_pready[1]},
            {1'b1, 1'b1, 4'b0000, 4'b0000});
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) m_psel = N'($urandom);
         rand_fields();
         s_pready  = ($urandom_range(0, 9) < 3);
         s_prdata  = $urandom;
         s_pslverr = 1'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
         end
         tick();
      end

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
